coinc_acq_ctrl: RTL and testbench
=================================

Name: coinc_acq_ctrl

Overview:
Acquisition sequencer for the coincidence detector datapath. It clears the detector's pair counters, enables counting for a programmable gate window, and waits for the pipeline to settle. It then snapshots all pair counts and streams them one pair per transfer over a valid/ready interface to the host/readout logic.

Parameters:
NCHAN, 4, number of input channels; NPAIR = NCHAN*(NCHAN-1)/2 is derived, not overridable
CWIDTH, 16, width of one pair count
GWIDTH, 24, width of gate-length register (cycles)
SETTLE, 2, post-gate wait cycles covering the detector delay/edge pipeline (must be >=1)

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
Start  in  1  begin acquisition (sampled in IDLE only)
Abort  in  1  cancel any acquisition in progress
GateLen  in  GWIDTH  gate length in cycles, latched at Start
CountsIn  in  NPAIR*CWIDTH  flattened detector pair counts, pair k at bits [k*CWIDTH +: CWIDTH]
DetClear  out  1  one-cycle synchronous clear to detector counters
DetEnable  out  1  detector count enable (gate)
Busy  out  1  high in every state except IDLE
OutValid  out  1  readout data valid
OutReady  in  1  readout sink ready
OutData  out  CWIDTH  snapshotted count of pair OutIdx
OutIdx  out  $clog2(NPAIR)  pair index
OutLast  out  1  high with the final pair (k = NPAIR-1)
Done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (async, Rst_n=0): state IDLE; all outputs 0; gate counter, settle counter, snapshot and index registers 0.
- Pair ordering: k enumerates (i,j) with i<j, in lexicographic order: (0,1)=0, (0,2)=1, ..., (NCHAN-2,NCHAN-1)=NPAIR-1.
- States: IDLE -> CLEAR -> GATE -> SETTLE -> LATCH -> READOUT -> DONE -> IDLE.
- IDLE: Start=1 and Abort=0 moves to CLEAR and latches G = GateLen. GateLen=0 is treated as G=1.
- CLEAR: DetClear=1 for exactly one cycle, then GATE.
- GATE: DetEnable=1 for exactly G consecutive cycles (down-counter), then SETTLE.
- SETTLE: DetEnable=0 for SETTLE cycles, then LATCH.
- LATCH: captures the entire CountsIn vector into the snapshot in one cycle; index k=0; next state READOUT.
- READOUT:
  - OutValid=1; OutData = snapshot[k]; OutIdx = k; OutLast = (k == NPAIR-1).
  - A transfer occurs on a cycle with OutValid&&OutReady; k then increments.
  - OutData, OutIdx and OutLast hold stable while OutValid&&!OutReady.
  - The transfer with OutLast moves to DONE; OutValid drops the next cycle.
- DONE: Done=1 for one cycle, then IDLE.
- Timing, with Start sampled at cycle t:
  - DetClear high at t+1.
  - DetEnable high t+2 .. t+1+G.
  - LATCH at t+2+G+SETTLE.
  - First OutValid at t+3+G+SETTLE.
  - With OutReady tied high: Done at t+4+G+SETTLE+NPAIR-1.
- Start outside IDLE is ignored. GateLen changes after latch have no effect.
- Abort=1 in any non-IDLE state: next cycle IDLE, with DetEnable, DetClear, OutValid and OutLast = 0. No Done pulse. The snapshot is not cleared.
- Abort and Start in the same IDLE cycle: Abort wins and the block stays IDLE.
- A new acquisition can start in the cycle after Done (IDLE).
- CountsIn is used only at LATCH; changes at any other time are ignored.
- No arithmetic wrap in the controller. The gate counter is GWIDTH bits, and G = 2^GWIDTH-1 must work.

Decomposition:
- Package coinc_pkg holds:
  - acq_state_t enum (IDLE, CLEAR, GATE, SETTLE, LATCH, READOUT, DONE);
  - function npair(nchan);
  - function pair_index(i,j,nchan), shared with the detector for consistent ordering.
- One sub-module: coinc_snapshot_ser (snapshot register + index counter + valid/ready output stage), controlled by load/start from the FSM. The FSM and timers stay in coinc_acq_ctrl.

Test Plan:
1. Reset mid-GATE (Rst_n low 2 cycles) -> all outputs 0 immediately; IDLE after release; no Done.
2. NCHAN=4, SETTLE=2, GateLen=5, Start at t, CountsIn pairs = 10,11,..,15, OutReady=1 -> DetClear at t+1; DetEnable t+2..t+6; OutValid t+10..t+15 with OutData 10..15, OutIdx 0..5; OutLast at t+15; Done at t+16.
3. Backpressure: OutReady low for 3 cycles at k=2 -> OutData=12, OutIdx=2 held stable; no skipped or duplicated pair; all 6 transfers complete.
4. GateLen=0 -> DetEnable high exactly 1 cycle; GateLen=2^24-1 -> gate counter does not wrap early (check DetEnable length with a shortened GWIDTH=4 build: 15 cycles).
5. Abort during READOUT at k=3 -> OutValid low next cycle, IDLE, no Done; a following Start runs a full clean sequence.
6. Start and Abort together in IDLE -> remains IDLE, DetClear never asserts; Start pulses during GATE are ignored (DetEnable length unchanged).

Source files
------------

// File: rtl/coinc_pkg.sv
// coinc_pkg: shared state type and pair-ordering helpers for the coincidence datapath
package coinc_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, READOUT, DONE} acq_state_t;

    function automatic int npair(input int nchan);
        return nchan * (nchan - 1) / 2;
    endfunction

    // Lexicographic (i,j), i<j: (0,1)=0, (0,2)=1, ..., (nchan-2,nchan-1)=npair-1
    function automatic int pair_index(input int i, input int j, input int nchan);
        return i * nchan - i * (i + 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/coinc_snapshot_ser.sv
// coinc_snapshot_ser: pair-count snapshot plus one-pair-per-transfer valid/ready serializer
module coinc_snapshot_ser #(
    parameter int NPAIR  = 6,
    parameter int CWIDTH = 16,
    parameter int IWIDTH = 3
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Load,
    input  logic                    Flush,
    input  logic [NPAIR*CWIDTH-1:0] CountsIn,
    input  logic                    OutReady,
    output logic                    OutValid,
    output logic [CWIDTH-1:0]       OutData,
    output logic [IWIDTH-1:0]       OutIdx,
    output logic                    OutLast
);

    logic [CWIDTH-1:0] snap [NPAIR];

    // Capture every pair count in the same cycle; hold it otherwise (a flush keeps it)
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            for (int p = 0; p < NPAIR; p++) snap[p] <= '0;
        else if (Load)
            for (int p = 0; p < NPAIR; p++) snap[p] <= CountsIn[p*CWIDTH +: CWIDTH];
    end

    // Output stage: start at pair 0 after a load, advance on each accepted transfer, stop after the last
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid <= 1'b0;
            OutIdx   <= '0;
            OutLast  <= 1'b0;
        end else if (Flush) begin
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
        end else if (Load) begin
            OutValid <= 1'b1;
            OutIdx   <= '0;
            OutLast  <= (NPAIR == 1);
        end else if (OutValid && OutReady) begin
            OutValid <= !OutLast;
            OutLast  <= OutIdx == IWIDTH'(NPAIR - 2);
            OutIdx   <= OutLast ? OutIdx : OutIdx + IWIDTH'(1);
        end
    end

    assign OutData = snap[OutIdx];

endmodule

// File: rtl/coinc_acq_ctrl.sv
// coinc_acq_ctrl: clear / gate / settle / snapshot / stream sequencer for the coincidence detector
module coinc_acq_ctrl import coinc_pkg::*; #(
    parameter int NCHAN  = 4,
    parameter int CWIDTH = 16,
    parameter int GWIDTH = 24,
    parameter int SETTLE = 2
) (
    input  logic                              Clk,
    input  logic                              Rst_n,
    input  logic                              Start,
    input  logic                              Abort,
    input  logic [GWIDTH-1:0]                 GateLen,
    input  logic [npair(NCHAN)*CWIDTH-1:0]    CountsIn,
    output logic                              DetClear,
    output logic                              DetEnable,
    output logic                              Busy,
    output logic                              OutValid,
    input  logic                              OutReady,
    output logic [CWIDTH-1:0]                 OutData,
    output logic [$clog2(npair(NCHAN))-1:0]   OutIdx,
    output logic                              OutLast,
    output logic                              Done
);

    localparam int NPAIR  = npair(NCHAN);
    localparam int IWIDTH = $clog2(NPAIR);
    localparam int SWIDTH = $clog2(SETTLE + 1);

    acq_state_t        state;
    logic [GWIDTH-1:0] gcnt;
    logic [SWIDTH-1:0] scnt;
    logic              flush;
    logic              load;

    assign Busy  = state != IDLE;
    assign flush = Abort && Busy;
    assign load  = state == LATCH;

    // Sequencer: gate counts down from the latched length, settle covers the detector pipeline
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            gcnt      <= '0;
            scnt      <= '0;
            DetClear  <= 1'b0;
            DetEnable <= 1'b0;
            Done      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            DetClear  <= 1'b0;
            DetEnable <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (Start && !Abort) begin
                        state    <= CLEAR;
                        gcnt     <= (GateLen == '0) ? GWIDTH'(1) : GateLen;
                        DetClear <= 1'b1;
                    end
                CLEAR: begin
                    state     <= GATE;
                    DetClear  <= 1'b0;
                    DetEnable <= 1'b1;
                end
                GATE:
                    if (gcnt == GWIDTH'(1)) begin
                        state     <= coinc_pkg::SETTLE;
                        DetEnable <= 1'b0;
                        scnt      <= SWIDTH'(SETTLE);
                    end else
                        gcnt <= gcnt - GWIDTH'(1);
                coinc_pkg::SETTLE:
                    if (scnt == SWIDTH'(1))
                        state <= LATCH;
                    else
                        scnt <= scnt - SWIDTH'(1);
                LATCH:
                    state <= READOUT;
                READOUT:
                    if (OutValid && OutReady && OutLast) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default:
                    state <= IDLE;
            endcase
        end
    end

    coinc_snapshot_ser #(
        .NPAIR  (NPAIR),
        .CWIDTH (CWIDTH),
        .IWIDTH (IWIDTH)
    ) u_ser (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Load     (load),
        .Flush    (flush),
        .CountsIn (CountsIn),
        .OutReady (OutReady),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutIdx   (OutIdx),
        .OutLast  (OutLast)
    );

endmodule

// File: tb/tb_coinc_acq_ctrl.sv
// tb_coinc_acq_ctrl: table-driven acquisitions with a readout scoreboard plus hand-written corner cases
module tb_coinc_acq_ctrl;

    localparam int NP = 6;
    localparam int CW = 16;

    logic           Clk = 0, Rst_n = 0, Start = 0, Abort = 0, OutReady = 1;
    logic [23:0]    GateLen = '0;
    logic [NP*CW-1:0] CountsIn = '0;
    logic           DetClear, DetEnable, Busy, OutValid, OutLast, Done;
    logic [CW-1:0]  OutData;
    logic [2:0]     OutIdx;

    logic           Start4 = 0;
    logic [3:0]     GateLen4 = '0;
    logic           DetClear4, DetEnable4, Busy4, OutValid4, OutLast4, Done4;
    logic [CW-1:0]  OutData4;
    logic [2:0]     OutIdx4;

    coinc_acq_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort), .GateLen(GateLen),
        .CountsIn(CountsIn), .DetClear(DetClear), .DetEnable(DetEnable), .Busy(Busy),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutIdx(OutIdx),
        .OutLast(OutLast), .Done(Done)
    );

    coinc_acq_ctrl #(.GWIDTH(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start4), .Abort(1'b0), .GateLen(GateLen4),
        .CountsIn(CountsIn), .DetClear(DetClear4), .DetEnable(DetEnable4), .Busy(Busy4),
        .OutValid(OutValid4), .OutReady(1'b1), .OutData(OutData4), .OutIdx(OutIdx4),
        .OutLast(OutLast4), .Done(Done4)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    typedef struct {int idx; int data; bit last;} exp_t;
    exp_t sb[$];

    typedef struct {
        logic [23:0] g;
        int base;
        int stall_k;
        int stall_n;
        int abort_k;
        bit gate_start;
        int exp_en;
        int exp_val;
        int exp_done;
        int exp_xfers;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One acquisition, observed at negedges; rel counts cycles after the Start sample edge
    task automatic acq(input vec_t v);
        int clr_at = -1, en_len = 0, en_first = -1, val_first = -1, done_at = -1, done_cnt = 0;
        int xfers = 0, stalled = 0, abort_rel = -1;
        sb.delete();
        for (int p = 0; p < NP; p++) begin
            sb.push_back('{idx: p, data: v.base + p, last: (p == NP - 1)});
            CountsIn[p*CW +: CW] = CW'(v.base + p);
        end
        @(negedge Clk);
        GateLen = v.g; Start = 1; OutReady = 1;
        @(negedge Clk);
        Start = 0; GateLen = 24'h00ABCD;
        for (int rel = 1; rel <= 40 + v.stall_n; rel++) begin
            Start = 0; Abort = 0;
            if (abort_rel > 0 && rel == abort_rel + 1) begin
                chk("abort_valid", OutValid, 0);
                chk("abort_last", OutLast, 0);
                chk("abort_busy", Busy, 0);
                sb.delete();
            end
            if (DetClear && clr_at < 0) clr_at = rel;
            if (DetEnable) begin
                en_len++;
                if (en_first < 0) en_first = rel;
                if (v.gate_start && en_len == 2) Start = 1;
            end
            if (Done) begin done_at = rel; done_cnt++; end
            if (OutValid) begin
                if (val_first < 0) begin val_first = rel; CountsIn = {NP{16'hDEAD}}; end
                if (v.abort_k >= 0 && OutIdx == 3'(v.abort_k)) begin
                    Abort = 1; OutReady = 0; abort_rel = rel;
                end else if (v.stall_n > 0 && OutIdx == 3'(v.stall_k) && stalled < v.stall_n) begin
                    OutReady = 0; stalled++;
                end else OutReady = 1;
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    chk("out_idx", OutIdx, sb[0].idx);
                    chk("out_data", OutData, sb[0].data);
                    chk("out_last", OutLast, sb[0].last);
                    if (OutReady) begin void'(sb.pop_front()); xfers++; end
                end
            end else OutReady = 1;
            @(negedge Clk);
        end
        chk("clr_at", clr_at, 1);
        chk("en_first", en_first, 2);
        chk("en_len", en_len, v.exp_en);
        chk("val_first", val_first, v.exp_val);
        chk("done_at", done_at, v.exp_done);
        chk("done_cnt", done_cnt, v.exp_done < 0 ? 0 : 1);
        chk("xfers", xfers, v.exp_xfers);
        chk("end_busy", Busy, 0);
    endtask

    initial begin
        int en_cnt, done_cnt, clr_cnt, busy_cnt;
        vecs[0] = '{24'd5, 10,    0, 0, -1, 1'b0, 5, 10, 16, 6};
        vecs[1] = '{24'd5, 10,    2, 3, -1, 1'b0, 5, 10, 19, 6};
        vecs[2] = '{24'd0, 100,   0, 0, -1, 1'b0, 1, 6,  12, 6};
        vecs[3] = '{24'd3, 7000,  0, 0, -1, 1'b1, 3, 8,  14, 6};
        vecs[4] = '{24'd2, 50,    0, 0,  3, 1'b0, 2, 7,  -1, 3};
        vecs[5] = '{24'd1, 60000, 0, 0, -1, 1'b0, 1, 6,  12, 6};

        repeat (2) @(negedge Clk);
        chk("rst_clear", DetClear, 0);
        chk("rst_enable", DetEnable, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", OutValid, 0);
        chk("rst_data", OutData, 0);
        chk("rst_idx", OutIdx, 0);
        chk("rst_last", OutLast, 0);
        chk("rst_done", Done, 0);
        Rst_n = 1;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) acq(vecs[i]);

        // Start and Abort together in IDLE
        Start = 1; Abort = 1;
        @(negedge Clk);
        Start = 0; Abort = 0;
        clr_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            clr_cnt += int'(DetClear); busy_cnt += int'(Busy);
            @(negedge Clk);
        end
        chk("startabort_clear", clr_cnt, 0);
        chk("startabort_busy", busy_cnt, 0);

        // Asynchronous reset in the middle of a gate
        GateLen = 24'd20; Start = 1;
        @(negedge Clk);
        Start = 0;
        repeat (5) @(negedge Clk);
        chk("pre_rst_enable", DetEnable, 1);
        #1 Rst_n = 0;
        #1;
        chk("midrst_enable", DetEnable, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_clear", DetClear, 0);
        chk("midrst_done", Done, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1;
        en_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            en_cnt += int'(DetEnable); done_cnt += int'(Done); busy_cnt += int'(Busy);
        end
        chk("postrst_enable", en_cnt, 0);
        chk("postrst_done", done_cnt, 0);
        chk("postrst_busy", busy_cnt, 0);

        // Full-scale gate on the narrow build
        GateLen4 = 4'hF; Start4 = 1;
        @(negedge Clk);
        Start4 = 0; GateLen4 = 4'h0;
        en_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            en_cnt += int'(DetEnable4); done_cnt += int'(Done4);
        end
        chk("g4_enable_len", en_cnt, 15);
        chk("g4_done", done_cnt, 1);
        chk("g4_busy", Busy4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
